// File: rtl/serial_pattern_transmitter_fsm.sv
// Serial pattern transmitter: accepts a request over valid/ready and shifts
// the pattern out MSB first on a, with optional repeats and idle gaps.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid      request present
//   req_ready      high only in IDLE
//   req_pattern    pattern bits, bit req_len-1 sent first
//   req_len        bits to send (clamped to MAX_LEN at acceptance)
//   req_repeat     extra repetitions (total sends = req_repeat+1)
//   req_gap        idle cycles between repetitions
//   a, a_valid     serial data and its qualifier (a=0 when not valid)
//   busy           high from the cycle after acceptance through DONE
//   done           one-cycle pulse at end of request
module serial_pattern_transmitter_fsm #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int RPT_W   = 4,
    parameter int GAP_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MAX_LEN-1:0] req_pattern,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [RPT_W-1:0]   req_repeat,
    input  logic [GAP_W-1:0]   req_gap,
    output logic               a,
    output logic               a_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [RPT_W-1:0]   rpt_q, rpt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;

    logic [LEN_W-1:0]   len_c;
    logic [MAX_LEN-1:0] pat_sh;

    // Clamp once at acceptance; the latched length is already legal.
    assign len_c = (req_len > MAX_L) ? MAX_L : req_len;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rpt_d   = rpt_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pat_d = req_pattern;
                    len_d = len_c;
                    rpt_d = req_repeat;
                    gap_d = req_gap;
                    if (len_c == '0) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = len_c - 1'b1;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else if (rpt_q != '0) begin
                    if (gap_q != '0) begin
                        gcnt_d  = gap_q;
                        state_d = GAP;
                    end else begin
                        // Back-to-back frame, no bubble.
                        idx_d = len_q - 1'b1;
                        rpt_d = rpt_q - 1'b1;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            GAP: begin
                if (gcnt_q <= GAP_W'(1)) begin
                    idx_d   = len_q - 1'b1;
                    rpt_d   = rpt_q - 1'b1;
                    state_d = SEND;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rpt_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rpt_q   <= rpt_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Shift instead of a variable bit-select so the index width is free.
    assign pat_sh    = pat_q >> idx_q;
    assign req_ready = (state_q == IDLE);
    assign a_valid   = (state_q == SEND);
    assign a         = a_valid & pat_sh[0];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_transmitter_fsm.sv
// Directed bench for serial_pattern_transmitter_fsm: expected bit stream
// per request is queued at issue and popped one entry per output cycle.
module tb_serial_pattern_transmitter_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_pattern;
    logic [3:0] req_len;
    logic [3:0] req_repeat;
    logic [2:0] req_gap;
    logic       a;
    logic       a_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic v;
        logic b;
        logic d;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] hist;

    always #5 clk = ~clk;

    serial_pattern_transmitter_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pattern (req_pattern),
        .req_len     (req_len),
        .req_repeat  (req_repeat),
        .req_gap     (req_gap),
        .a           (a),
        .a_valid     (a_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one request, one entry per cycle after acceptance.
    task automatic build(input logic [7:0] pat, input int len,
                         input int rpt, input int gap);
        int l;
        l = (len > 8) ? 8 : len;
        for (int r = 0; r <= rpt; r++) begin
            for (int k = l - 1; k >= 0; k--) begin
                exp_q.push_back('{v: 1'b1, b: pat[k], d: 1'b0});
            end
            if (r < rpt) begin
                for (int g = 0; g < gap; g++) begin
                    exp_q.push_back('{v: 1'b0, b: 1'b0, d: 1'b0});
                end
            end
        end
        exp_q.push_back('{v: 1'b0, b: 1'b0, d: 1'b1});
    endtask

    // Called #1 after the accepting edge; ends #1 into the following IDLE cycle.
    task automatic drain(input bit scramble);
        exp_t e;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("a_valid", 32'(a_valid), 32'(e.v));
            chk("a", 32'(a), 32'(e.b));
            chk("done", 32'(done), 32'(e.d));
            chk("busy", 32'(busy), 32'd1);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (a_valid) hist = {hist[4:0], a};
            if (scramble) begin
                req_pattern = 8'($urandom);
                req_len     = 4'($urandom);
                req_repeat  = 4'($urandom);
                req_gap     = 3'($urandom);
            end
            @(posedge clk);
            #1;
        end
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_a_valid", 32'(a_valid), 32'd0);
    endtask

    // Called in an IDLE cycle; issues the request and checks it fully.
    task automatic send(input logic [7:0] pat, input int len,
                        input int rpt, input int gap, input bit hold);
        req_pattern = pat;
        req_len     = 4'(len);
        req_repeat  = 4'(rpt);
        req_gap     = 3'(gap);
        req_valid   = 1'b1;
        chk("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        build(pat, len, rpt, gap);
        drain(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_pattern = '0;
        req_len     = '0;
        req_repeat  = '0;
        req_gap     = '0;
        hist        = '0;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        req_valid   = 1'b1;
        req_len     = 4'd3;
        req_pattern = 8'hFF;
        @(posedge clk);
        #1;
        chk("rst_blocks_accept", 32'(busy), 32'd0);
        req_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;

        send(8'b0011_0011, 6, 0, 0, 1'b0);
        chk("loopback_110011", 32'(hist), 32'b110011);

        send(8'h0A, 4, 1, 2, 1'b0);
        send(8'h0A, 4, 2, 0, 1'b0);
        send(8'h00, 0, 0, 0, 1'b0);
        send(8'hA5, 9, 0, 0, 1'b0);
        send(8'h6C, 3, 3, 1, 1'b0);

        // Reset while the third bit is on the line.
        req_pattern = 8'b0011_0110;
        req_len     = 4'd6;
        req_repeat  = 4'd0;
        req_gap     = 3'd0;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_bit3", 32'(a), 32'd0);
        chk("pre_rst_valid", 32'(a_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_valid", 32'(a_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        send(8'b0010_1101, 6, 0, 0, 1'b0);

        // Held valid with scrambled inputs while busy.
        send(8'hC3, 8, 1, 0, 1'b1);
        send(8'h05, 3, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
